// File: rtl/fadd_pkg.sv
// -----------------------------------------------------------------------------
// fadd_pkg
// Shared constants and state encoding for the half-precision adder back end.
//   MW   : mantissa width including the hidden bit
//   EW   : exponent width
//   EMAX : all-ones exponent (Inf)
// -----------------------------------------------------------------------------
package fadd_pkg;

  localparam int MW   = 11;
  localparam int EW   = 5;
  localparam int EMAX = 31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fadd_recomp.sv
// -----------------------------------------------------------------------------
// fadd_recomp
// Combinational MW-bit conditional two's complement. Undoes the complement
// applied by the upstream operand mux when the subtraction result went negative.
// Ports:
//   a   in  MW  raw mantissa sum
//   neg in  1   1 = return (~a + 1) mod 2^MW, 0 = pass a through
//   y   out MW  recomplemented value
// -----------------------------------------------------------------------------
module fadd_recomp
  import fadd_pkg::*;
(
  input  logic [MW-1:0] a,
  input  logic          neg,
  output logic [MW-1:0] y
);

  // Two's complement select; the +1 wraps modulo 2^MW by construction.
  always_comb begin
    y = a;
    if (neg) begin
      y = ~a + {{(MW-1){1'b0}}, 1'b1};
    end else begin
      y = a;
    end
  end

endmodule

// File: rtl/fadd_normalizer.sv
// -----------------------------------------------------------------------------
// fadd_normalizer
// Back end of the half-precision float adder. Fixes up the raw mantissa sum
// (carry-out, negative result) on accept, then normalises it with one left
// shift and one exponent decrement per cycle. Valid/ready on both sides.
// Ports:
//   clk, reset_n                clock (rising edge), async active-low reset
//   in_valid / in_ready         input handshake (in_ready high only in IDLE)
//   sum, carry, sub_op          raw adder sum, carry-out, effective subtract
//   exp_in, sign_in             common exponent, sign of larger operand
//   out_valid / out_ready       output handshake (out_valid held until ready)
//   mant_out, exp_out, sign_out normalised result (mant_out[MW-1] = hidden bit)
//   zero, ovf                   exact-zero and exponent-overflow flags
// -----------------------------------------------------------------------------
module fadd_normalizer
  import fadd_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] sum,
  input  logic          carry,
  input  logic          sub_op,
  input  logic [EW-1:0] exp_in,
  input  logic          sign_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] mant_out,
  output logic [EW-1:0] exp_out,
  output logic          sign_out,
  output logic          zero,
  output logic          ovf
);

  localparam logic [EW-1:0] EXP_MAX  = EW'(EMAX);
  localparam logic [EW-1:0] EXP_PRE  = EW'(EMAX - 1);
  localparam logic [EW-1:0] EXP_ONE  = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [EW-1:0] EXP_ZERO = {EW{1'b0}};
  localparam logic [MW-1:0] MANT_ZERO = {MW{1'b0}};

  state_t        state_r;
  logic [MW-1:0] mant_r;
  logic [EW-1:0] exp_r;
  logic          sign_r;
  logic          zero_r;
  logic          ovf_r;
  logic          in_ready_r;
  logic          out_valid_r;

  logic          neg_s;
  logic [MW-1:0] recomp_y_s;
  logic [MW-1:0] mant_fix_s;
  logic [EW-1:0] exp_fix_s;
  logic          sign_fix_s;
  logic          ovf_fix_s;

  // A subtract without carry-out means B > A: the sum is negative.
  assign neg_s = sub_op & ~carry;

  fadd_recomp u_recomp (
    .a   (sum),
    .neg (neg_s),
    .y   (recomp_y_s)
  );

  // Fix-up of the accepted inputs: recomplement, carry shift-in, overflow.
  always_comb begin
    mant_fix_s = recomp_y_s;
    exp_fix_s  = exp_in;
    sign_fix_s = sign_in;
    ovf_fix_s  = 1'b0;
    case ({sub_op, carry})
      2'b11: begin
        // Subtract with carry: result positive, carry is dropped.
        mant_fix_s = recomp_y_s;
      end
      2'b10: begin
        sign_fix_s = ~sign_in;
      end
      2'b01: begin
        if (exp_in == EXP_PRE) begin
          ovf_fix_s  = 1'b1;
          exp_fix_s  = EXP_MAX;
          mant_fix_s = MANT_ZERO;
        end else begin
          mant_fix_s = {1'b1, sum[MW-1:1]};
          exp_fix_s  = exp_in + EXP_ONE;
        end
      end
      default: begin
        mant_fix_s = recomp_y_s;
      end
    endcase
  end

  // Control FSM plus result registers; all outputs come straight from flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      mant_r      <= MANT_ZERO;
      exp_r       <= EXP_ZERO;
      sign_r      <= 1'b0;
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready_r) begin
            mant_r     <= mant_fix_s;
            exp_r      <= exp_fix_s;
            sign_r     <= sign_fix_s;
            ovf_r      <= ovf_fix_s;
            zero_r     <= 1'b0;
            in_ready_r <= 1'b0;
            // Overflow result is already final (Inf), skip normalisation.
            state_r    <= ovf_fix_s ? ST_DONE : ST_NORM;
          end
        end
        ST_NORM: begin
          if (mant_r == MANT_ZERO) begin
            zero_r  <= 1'b1;
            exp_r   <= EXP_ZERO;
            sign_r  <= 1'b0;
            state_r <= ST_DONE;
          end else if (mant_r[MW-1]) begin
            state_r <= ST_DONE;
          end else if (exp_r <= EXP_ONE) begin
            // Cannot shift further without underflow: deliver as subnormal.
            exp_r   <= EXP_ZERO;
            state_r <= ST_DONE;
          end else begin
            mant_r <= {mant_r[MW-2:0], 1'b0};
            exp_r  <= exp_r - EXP_ONE;
          end
        end
        ST_DONE: begin
          // First DONE cycle raises out_valid; handshake needs it already high.
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign mant_out  = mant_r;
  assign exp_out   = exp_r;
  assign sign_out  = sign_r;
  assign zero      = zero_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_fadd_normalizer.sv
// -----------------------------------------------------------------------------
// tb_fadd_normalizer
// Directed bench for fadd_normalizer with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_fadd_normalizer;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] sum;
  logic        carry;
  logic        sub_op;
  logic [4:0]  exp_in;
  logic        sign_in;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] mant_out;
  logic [4:0]  exp_out;
  logic        sign_out;
  logic        zero;
  logic        ovf;

  int passed = 0;
  int total  = 0;
  int lat;

  fadd_normalizer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .carry     (carry),
    .sub_op    (sub_op),
    .exp_in    (exp_in),
    .sign_in   (sign_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mant_out  (mant_out),
    .exp_out   (exp_out),
    .sign_out  (sign_out),
    .zero      (zero),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Present one input for a single accept edge, then count cycles to out_valid.
  task automatic run(input logic s_op, input logic cy, input logic [10:0] sm,
                     input logic [4:0] ex, input logic sg);
    sub_op   = s_op;
    carry    = cy;
    sum      = sm;
    exp_in   = ex;
    sign_in  = sg;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Complete the output handshake and confirm the return to IDLE.
  task automatic finish_txn(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ovalid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_iready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum       = 11'h000;
    carry     = 1'b0;
    sub_op    = 1'b0;
    exp_in    = 5'd0;
    sign_in   = 1'b0;
    #23;
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mant",      {21'd0, mant_out},  32'd0);
    check("rst_exp",       {27'd0, exp_out},   32'd0);
    check("rst_flags",     {29'd0, sign_out, zero, ovf}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: add with carry, already normalised after shift-in
    run(1'b0, 1'b1, 11'h400, 5'd15, 1'b0);
    check("t1_lat",  lat, 32'd2);
    check("t1_mant", {21'd0, mant_out}, 32'h600);
    check("t1_exp",  {27'd0, exp_out},  32'd16);
    check("t1_in_ready_busy", {31'd0, in_ready}, 32'd0);
    finish_txn("t1");

    // 2: subtract with carry, two normalisation shifts
    run(1'b1, 1'b1, 11'h100, 5'd15, 1'b0);
    check("t2_lat",  lat, 32'd4);
    check("t2_mant", {21'd0, mant_out}, 32'h400);
    check("t2_exp",  {27'd0, exp_out},  32'd13);
    finish_txn("t2");

    // 3: negative result, recomplement gives 0x100, sign flips
    run(1'b1, 1'b0, 11'h700, 5'd10, 1'b0);
    check("t3_lat",  lat, 32'd4);
    check("t3_sign", {31'd0, sign_out}, 32'd1);
    check("t3_mant", {21'd0, mant_out}, 32'h400);
    check("t3_exp",  {27'd0, exp_out},  32'd8);

    // 6: backpressure, five cycles in DONE with out_ready low
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid",    {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready},  32'd0);
      check("bp_mant",     {21'd0, mant_out},  32'h400);
      check("bp_exp",      {27'd0, exp_out},   32'd8);
    end
    finish_txn("t3");

    // 4: exact zero
    run(1'b1, 1'b1, 11'h000, 5'd12, 1'b1);
    check("t4_lat",  lat, 32'd2);
    check("t4_zero", {31'd0, zero},     32'd1);
    check("t4_exp",  {27'd0, exp_out},  32'd0);
    check("t4_sign", {31'd0, sign_out}, 32'd0);
    check("t4_mant", {21'd0, mant_out}, 32'h000);
    finish_txn("t4");

    // 5: exponent overflow goes straight to DONE; zero from t4 must clear
    run(1'b0, 1'b1, 11'h7FF, 5'd30, 1'b0);
    check("t5_lat",  lat, 32'd1);
    check("t5_ovf",  {31'd0, ovf},      32'd1);
    check("t5_zero", {31'd0, zero},     32'd0);
    check("t5_exp",  {27'd0, exp_out},  32'd31);
    check("t5_mant", {21'd0, mant_out}, 32'h000);
    finish_txn("t5");

    // 5b: subnormal stop at exp<=1; ovf from t5 must clear
    run(1'b1, 1'b1, 11'h001, 5'd3, 1'b0);
    check("sub_lat",  lat, 32'd4);
    check("sub_exp",  {27'd0, exp_out},  32'd0);
    check("sub_mant", {21'd0, mant_out}, 32'h004);
    check("sub_ovf",  {31'd0, ovf},      32'd0);
    finish_txn("sub");

    // 6b: async reset in the middle of normalisation
    sub_op   = 1'b0;
    carry    = 1'b0;
    sum      = 11'h001;
    exp_in   = 5'd20;
    sign_in  = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    check("mid_mant", {21'd0, mant_out}, 32'h008);
    check("mid_exp",  {27'd0, exp_out},  32'd17);
    reset_n = 1'b0;
    #2;
    check("ar_in_ready",  {31'd0, in_ready},  32'd1);
    check("ar_out_valid", {31'd0, out_valid}, 32'd0);
    check("ar_mant",      {21'd0, mant_out},  32'd0);
    check("ar_exp",       {27'd0, exp_out},   32'd0);
    check("ar_flags",     {29'd0, sign_out, zero, ovf}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Worst case: ten shifts, out_valid MW+1 cycles after accept
    run(1'b0, 1'b0, 11'h001, 5'd20, 1'b1);
    check("wc_lat",  lat, 32'd12);
    check("wc_mant", {21'd0, mant_out}, 32'h400);
    check("wc_exp",  {27'd0, exp_out},  32'd10);
    check("wc_sign", {31'd0, sign_out}, 32'd1);
    finish_txn("wc");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
